// File: rtl/wb_set_assoc_cache_if.sv
// Core-side request/response and memory-side beat bus of the write-back set-associative cache.
// The slave modport is the cache itself; the master modport is the core plus the next memory level.
interface wb_set_assoc_cache_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    resp_valid;
  logic [DATA_WIDTH-1:0]   resp_rdata;
  logic                    flush;
  logic                    flush_done;
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_we;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_resp_valid;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, flush,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, flush_done,
    output mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, flush,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, flush_done,
    input  mem_req_valid, mem_req_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/wb_set_assoc_cache.sv
// Write-back, write-allocate N-way set-associative data cache with true-LRU replacement,
// burst writeback/refill over a one-beat-at-a-time memory port, byte enables and whole-cache flush.
module wb_set_assoc_cache #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned N_WAYS          = 2,
  parameter int unsigned NUM_SETS        = 16,
  parameter int unsigned WORDS_PER_BLOCK = 8
) (
  input logic                clk,
  input logic                rst,
  wb_set_assoc_cache_if.slave bus
);
  localparam int unsigned BE_W     = DATA_WIDTH / 8;
  localparam int unsigned BYTE_OFF = $clog2(BE_W);
  localparam int unsigned WORD_OFF = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned INDEX    = $clog2(NUM_SETS);
  localparam int unsigned TAG      = ADDR_WIDTH - INDEX - WORD_OFF - BYTE_OFF;
  localparam int unsigned WAY_W    = $clog2(N_WAYS);

  typedef enum logic [2:0] {
    StIdle, StWb, StRfReq, StRfWait, StResp, StFlushScan, StFlushWb
  } state_e;

  // Line storage and per-set metadata
  logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][N_WAYS][WORDS_PER_BLOCK];
  logic [TAG-1:0]        tag_q   [NUM_SETS][N_WAYS];
  logic [N_WAYS-1:0]     valid_q [NUM_SETS];
  logic [N_WAYS-1:0]     dirty_q [NUM_SETS];
  logic [WAY_W-1:0]      lru_q   [NUM_SETS][N_WAYS];

  state_e                state_q, state_d;
  logic [WORD_OFF-1:0]   beat_q, beat_d;
  logic [INDEX-1:0]      set_q, set_d;
  logic [WAY_W-1:0]      way_q, way_d;
  logic [TAG-1:0]        lat_tag_q, lat_tag_d;
  logic [WORD_OFF-1:0]   lat_word_q, lat_word_d;
  logic                  lat_we_q, lat_we_d;
  logic [DATA_WIDTH-1:0] lat_wdata_q, lat_wdata_d;
  logic [BE_W-1:0]       lat_be_q, lat_be_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                  flush_done_q, flush_done_d;

  logic [INDEX-1:0]      req_index;
  logic [TAG-1:0]        req_tag;
  logic [WORD_OFF-1:0]   req_word;
  logic                  accept, flush_go;
  logic                  hit, inv_found;
  logic [WAY_W-1:0]      hit_way, inv_way, lru_way, victim_way;

  logic [INDEX-1:0]      acc_set;
  logic [WAY_W-1:0]      acc_way;
  logic [WORD_OFF-1:0]   acc_word;
  logic                  acc_we;
  logic [DATA_WIDTH-1:0] acc_wdata, old_word, merged, acc_result;
  logic [BE_W-1:0]       acc_be;
  logic [WAY_W-1:0]      lru_new [N_WAYS];

  logic                  data_we, tag_fill, dirty_set, dirty_clr, lru_we;
  logic [INDEX-1:0]      data_set;
  logic [WAY_W-1:0]      data_way;
  logic [WORD_OFF-1:0]   data_word;
  logic [DATA_WIDTH-1:0] data_wval;

  logic                  mem_valid_c, mem_we_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [DATA_WIDTH-1:0] mem_wdata_c;
  logic                  unused_addr_bits;

  function automatic logic [ADDR_WIDTH-1:0] make_addr(input logic [TAG-1:0] t,
                                                      input logic [INDEX-1:0] s,
                                                      input logic [WORD_OFF-1:0] wd);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    a[ADDR_WIDTH-1 -: TAG]            = t;
    a[BYTE_OFF+WORD_OFF +: INDEX]     = s;
    a[BYTE_OFF +: WORD_OFF]           = wd;
    return a;
  endfunction

  assign req_index        = bus.req_addr[BYTE_OFF+WORD_OFF +: INDEX];
  assign req_tag          = bus.req_addr[ADDR_WIDTH-1 -: TAG];
  assign req_word         = bus.req_addr[BYTE_OFF +: WORD_OFF];
  assign unused_addr_bits = ^bus.req_addr[BYTE_OFF-1:0];

  assign bus.req_ready = (state_q == StIdle) & ~rst;
  assign flush_go      = bus.flush & bus.req_ready;
  assign accept        = bus.req_valid & bus.req_ready & ~bus.flush;

  // Beat outputs read zero whenever no beat is being offered, including during reset
  assign bus.mem_req_valid = mem_valid_c & ~rst;
  assign bus.mem_req_we    = bus.mem_req_valid & mem_we_c;
  assign bus.mem_addr      = bus.mem_req_valid ? mem_addr_c : '0;
  assign bus.mem_wdata     = bus.mem_req_valid ? mem_wdata_c : '0;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.flush_done    = flush_done_q;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    lru_way   = '0;
    for (int w = 0; w < int'(N_WAYS); w++) begin
      if (!hit && valid_q[req_index][w] && (tag_q[req_index][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (lru_q[req_index][w] == WAY_W'(N_WAYS - 1)) lru_way = WAY_W'(w);
    end
    for (int w = int'(N_WAYS) - 1; w >= 0; w--) begin
      if (!valid_q[req_index][w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    victim_way = inv_found ? inv_way : lru_way;
  end

  // The word access is shared by the hit path (IDLE) and the post-refill path (RESP)
  always_comb begin
    if (state_q == StResp) begin
      acc_set   = set_q;
      acc_way   = way_q;
      acc_word  = lat_word_q;
      acc_we    = lat_we_q;
      acc_wdata = lat_wdata_q;
      acc_be    = lat_be_q;
    end else begin
      acc_set   = req_index;
      acc_way   = hit_way;
      acc_word  = req_word;
      acc_we    = bus.req_we;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end
    old_word = data_q[acc_set][acc_way][acc_word];
    merged   = old_word;
    for (int b = 0; b < int'(BE_W); b++) begin
      if (acc_be[b]) merged[8*b +: 8] = acc_wdata[8*b +: 8];
    end
    acc_result = acc_we ? merged : old_word;
    for (int w = 0; w < int'(N_WAYS); w++) begin
      if (WAY_W'(w) == acc_way)                           lru_new[w] = '0;
      else if (lru_q[acc_set][w] < lru_q[acc_set][acc_way]) lru_new[w] = lru_q[acc_set][w] + 1'b1;
      else                                                lru_new[w] = lru_q[acc_set][w];
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    set_d        = set_q;
    way_d        = way_q;
    lat_tag_d    = lat_tag_q;
    lat_word_d   = lat_word_q;
    lat_we_d     = lat_we_q;
    lat_wdata_d  = lat_wdata_q;
    lat_be_d     = lat_be_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    flush_done_d = 1'b0;
    mem_valid_c  = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr_c   = '0;
    mem_wdata_c  = '0;
    data_we      = 1'b0;
    data_set     = acc_set;
    data_way     = acc_way;
    data_word    = acc_word;
    data_wval    = merged;
    tag_fill     = 1'b0;
    dirty_set    = 1'b0;
    dirty_clr    = 1'b0;
    lru_we       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_go) begin
          set_d   = '0;
          way_d   = '0;
          state_d = StFlushScan;
        end else if (accept) begin
          if (hit) begin
            data_we      = bus.req_we;
            dirty_set    = bus.req_we;
            lru_we       = 1'b1;
            resp_valid_d = 1'b1;
            resp_rdata_d = acc_result;
          end else begin
            set_d       = req_index;
            way_d       = victim_way;
            lat_tag_d   = req_tag;
            lat_word_d  = req_word;
            lat_we_d    = bus.req_we;
            lat_wdata_d = bus.req_wdata;
            lat_be_d    = bus.req_be;
            beat_d      = '0;
            state_d     = (valid_q[req_index][victim_way] && dirty_q[req_index][victim_way]) ?
                          StWb : StRfReq;
          end
        end
      end
      StWb, StFlushWb: begin
        mem_valid_c = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = make_addr(tag_q[set_q][way_q], set_q, beat_q);
        mem_wdata_c = data_q[set_q][way_q][beat_q];
        if (bus.mem_req_ready) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == WORD_OFF'(WORDS_PER_BLOCK - 1)) begin
            dirty_clr = (state_q == StFlushWb);
            state_d   = (state_q == StWb) ? StRfReq : StFlushScan;
          end
        end
      end
      StRfReq: begin
        mem_valid_c = 1'b1;
        mem_addr_c  = make_addr(lat_tag_q, set_q, beat_q);
        if (bus.mem_req_ready) state_d = StRfWait;
      end
      StRfWait: begin
        if (bus.mem_resp_valid) begin
          data_we   = 1'b1;
          data_set  = set_q;
          data_way  = way_q;
          data_word = beat_q;
          data_wval = bus.mem_rdata;
          beat_d    = beat_q + 1'b1;
          if (beat_q == WORD_OFF'(WORDS_PER_BLOCK - 1)) begin
            tag_fill = 1'b1;
            state_d  = StResp;
          end else begin
            state_d  = StRfReq;
          end
        end
      end
      StResp: begin
        data_we      = lat_we_q;
        dirty_set    = lat_we_q;
        lru_we       = 1'b1;
        resp_valid_d = 1'b1;
        resp_rdata_d = acc_result;
        state_d      = StIdle;
      end
      StFlushScan: begin
        // A written-back line returns here with dirty cleared, so the scan then moves on
        if (valid_q[set_q][way_q] && dirty_q[set_q][way_q]) begin
          beat_d  = '0;
          state_d = StFlushWb;
        end else if (way_q == WAY_W'(N_WAYS - 1)) begin
          way_d = '0;
          if (set_q == INDEX'(NUM_SETS - 1)) begin
            flush_done_d = 1'b1;
            state_d      = StIdle;
          end else begin
            set_d = set_q + 1'b1;
          end
        end else begin
          way_d = way_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      beat_q       <= '0;
      set_q        <= '0;
      way_q        <= '0;
      lat_tag_q    <= '0;
      lat_word_q   <= '0;
      lat_we_q     <= 1'b0;
      lat_wdata_q  <= '0;
      lat_be_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      set_q        <= set_d;
      way_q        <= way_d;
      lat_tag_q    <= lat_tag_d;
      lat_word_q   <= lat_word_d;
      lat_we_q     <= lat_we_d;
      lat_wdata_q  <= lat_wdata_d;
      lat_be_q     <= lat_be_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      flush_done_q <= flush_done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < int'(NUM_SETS); s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < int'(N_WAYS); w++) lru_q[s][w] <= WAY_W'(w);
      end
    end else begin
      if (data_we) data_q[data_set][data_way][data_word] <= data_wval;
      if (tag_fill) begin
        tag_q[set_q][way_q]   <= lat_tag_q;
        valid_q[set_q][way_q] <= 1'b1;
        dirty_q[set_q][way_q] <= 1'b0;
      end
      if (dirty_set) dirty_q[acc_set][acc_way] <= 1'b1;
      if (dirty_clr) dirty_q[set_q][way_q] <= 1'b0;
      if (lru_we) lru_q[acc_set] <= lru_new;
    end
  end
endmodule

// File: tb/tb_wb_set_assoc_cache.sv
// Directed bench for wb_set_assoc_cache: a small beat-level memory model with optional
// backpressure, and hand-computed expected data, beat addresses and beat counts.
module tb_wb_set_assoc_cache;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_set_assoc_cache_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

  wb_set_assoc_cache #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .N_WAYS(2), .NUM_SETS(16), .WORDS_PER_BLOCK(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Memory model and beat log
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] rd_addr[$];
  int          resp_cnt = 0;
  int          fd_cnt = 0;
  bit          stall_arm = 0;
  bit          stall_hit = 0;
  int          stall_left = 0;
  logic [31:0] stall_addr, stall_data;
  bit          rd_pending = 0;
  logic [31:0] rd_data;

  task automatic clr();
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
  endtask

  initial begin
    bus.mem_req_ready  = 1'b1;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      if (rd_pending) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_rdata      = rd_data;
        rd_pending         = 0;
      end
      if (bus.resp_valid) resp_cnt++;
      if (bus.flush_done) fd_cnt++;
      if (stall_left > 0) begin
        bus.mem_req_ready = 1'b0;
        stall_left--;
        check("stall_valid", {31'd0, bus.mem_req_valid}, 32'd1);
        check("stall_addr", bus.mem_addr, stall_addr);
        check("stall_wdata", bus.mem_wdata, stall_data);
        check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
      end else begin
        bus.mem_req_ready = 1'b1;
        if (stall_arm && bus.mem_req_valid && bus.mem_req_we && wr_addr.size() == 3) begin
          stall_arm         = 0;
          stall_hit         = 1;
          stall_left        = 4;
          stall_addr        = bus.mem_addr;
          stall_data        = bus.mem_wdata;
          bus.mem_req_ready = 1'b0;
        end
      end
      if (bus.mem_req_valid && bus.mem_req_ready) begin
        if (bus.mem_req_we) begin
          wr_addr.push_back(bus.mem_addr);
          wr_data.push_back(bus.mem_wdata);
          mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          rd_addr.push_back(bus.mem_addr);
          rd_data    = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'd0;
          rd_pending = 1;
        end
      end
    end
  end

  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] rdata, output int lat);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_be    = be;
    @(negedge clk);
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.resp_valid) check("resp_timeout", {31'd0, bus.resp_valid}, 32'd1);
    rdata = bus.resp_rdata;
  endtask

  task automatic check_reads(input string tag, input logic [31:0] base);
    check({tag, "_rd_beats"}, rd_addr.size(), 32'd8);
    for (int k = 0; k < 8 && k < rd_addr.size(); k++)
      check({tag, "_rd_addr"}, rd_addr[k], base + 32'(4 * k));
  endtask

  logic [31:0] rd;
  int          lat;
  logic [31:0] exp_wb [8];
  int          n;
  int          rc0, fd0;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_be    = '0;
    bus.flush     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      mem[32'h100 + 32'(4 * k)] = 32'hA0 + 32'(k);
      mem[32'h300 + 32'(4 * k)] = 32'hB0 + 32'(k);
      mem[32'h500 + 32'(4 * k)] = 32'hC0 + 32'(k);
      mem[32'h700 + 32'(4 * k)] = 32'hD0 + 32'(k);
      mem[32'h900 + 32'(4 * k)] = 32'hE0 + 32'(k);
    end

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_flush_done", {31'd0, bus.flush_done}, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // 1: cold miss refill, then a hit on the same line
    clr();
    access(0, 32'h100, 32'd0, 4'h0, rd, lat);
    check("t1_miss_data", rd, 32'h0000_00A0);
    check_reads("t1", 32'h100);
    check("t1_wr_beats", wr_addr.size(), 32'd0);
    clr();
    access(0, 32'h104, 32'd0, 4'h0, rd, lat);
    check("t1_hit_data", rd, 32'h0000_00A1);
    check("t1_hit_lat", lat, 32'd1);
    check("t1_hit_beats", rd_addr.size() + wr_addr.size(), 32'd0);

    // 2: partial store hit
    access(1, 32'h104, 32'hDEAD_BEEF, 4'b0011, rd, lat);
    check("t2_store_resp", rd, 32'h0000_BEEF);
    check("t2_store_lat", lat, 32'd1);
    access(0, 32'h104, 32'd0, 4'h0, rd, lat);
    check("t2_reload", rd, 32'h0000_BEEF);

    // 3: conflicts in set 8
    access(1, 32'h100, 32'h1111_1111, 4'hF, rd, lat);
    check("t3_store_resp", rd, 32'h1111_1111);
    clr();
    access(0, 32'h300, 32'd0, 4'h0, rd, lat);
    check("t3_load300", rd, 32'h0000_00B0);
    check("t3_300_wr_beats", wr_addr.size(), 32'd0);
    check_reads("t3_300", 32'h300);
    access(0, 32'h100, 32'd0, 4'h0, rd, lat);
    check("t3_reload100", rd, 32'h1111_1111);
    check("t3_reload100_lat", lat, 32'd1);
    clr();
    access(0, 32'h500, 32'd0, 4'h0, rd, lat);
    check("t3_load500", rd, 32'h0000_00C0);
    check("t3_clean_evict_wr", wr_addr.size(), 32'd0);
    check_reads("t3_500", 32'h500);

    // 3+4: dirty eviction of 0x100 with a 5-cycle stall mid-writeback
    exp_wb[0] = 32'h1111_1111;
    exp_wb[1] = 32'h0000_BEEF;
    for (int k = 2; k < 8; k++) exp_wb[k] = 32'hA0 + 32'(k);
    clr();
    stall_arm = 1;
    access(0, 32'h700, 32'd0, 4'h0, rd, lat);
    check("t3_load700", rd, 32'h0000_00D0);
    check("t4_stall_seen", {31'd0, stall_hit}, 32'd1);
    check("t3_wb_beats", wr_addr.size(), 32'd8);
    for (int k = 0; k < 8 && k < wr_addr.size(); k++) begin
      check("t3_wb_addr", wr_addr[k], 32'h100 + 32'(4 * k));
      check("t3_wb_data", wr_data[k], exp_wb[k]);
    end
    check_reads("t3_700", 32'h700);

    // 5: flush with two dirty lines, flush beats a simultaneous request
    access(1, 32'h700, 32'h0000_0077, 4'hF, rd, lat);
    check("t5_store700", rd, 32'h0000_0077);
    access(1, 32'h504, 32'hAABB_CCDD, 4'b0100, rd, lat);
    check("t5_store504", rd, 32'h00BB_00C1);
    clr();
    rc0 = resp_cnt;
    fd0 = fd_cnt;
    @(negedge clk);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h100;
    @(negedge clk);
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    n = 0;
    while (fd_cnt == fd0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("t5_flush_done_pulses", fd_cnt - fd0, 32'd1);
    check("t5_req_not_accepted", resp_cnt - rc0, 32'd0);
    check("t5_wr_beats", wr_addr.size(), 32'd16);
    check("t5_rd_beats", rd_addr.size(), 32'd0);
    if (wr_addr.size() >= 16) begin
      check("t5_first_addr", wr_addr[0], 32'h700);
      check("t5_first_data", wr_data[0], 32'h0000_0077);
      check("t5_second_line_addr", wr_addr[8], 32'h500);
      check("t5_second_line_word1", wr_data[9], 32'h00BB_00C1);
      check("t5_last_addr", wr_addr[15], 32'h51C);
    end
    clr();
    access(0, 32'h700, 32'd0, 4'h0, rd, lat);
    check("t5_reread700", rd, 32'h0000_0077);
    check("t5_reread700_lat", lat, 32'd1);
    access(0, 32'h504, 32'd0, 4'h0, rd, lat);
    check("t5_reread504", rd, 32'h00BB_00C1);
    check("t5_reread_beats", rd_addr.size() + wr_addr.size(), 32'd0);

    // 6: reset in the middle of a refill
    clr();
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 32'h900;
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (rd_addr.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("t6_refill_started", {31'd0, rd_addr.size() >= 3}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_mem_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
    check("t6_req_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    clr();
    access(0, 32'h900, 32'd0, 4'h0, rd, lat);
    check("t6_reload", rd, 32'h0000_00E0);
    check("t6_is_miss", {31'd0, lat > 1}, 32'd1);
    check_reads("t6", 32'h900);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_set_assoc_cache.md
Name: wb_set_assoc_cache

Overview:
Parametrised write-back, write-allocate, N-way set-associative data cache with true-LRU replacement. It sits between the core load/store unit and the next memory level, with valid/ready handshakes on both sides. Compared with the current cache, it adds:
- burst writeback of dirty victims and burst refill, both with backpressure;
- byte-enable writes;
- a whole-cache flush command.

Parameters:
- DATA_WIDTH, 32, word width in bits (multiple of 8)
- ADDR_WIDTH, 32, byte address width
- N_WAYS, 2, associativity (power of 2, >=2)
- NUM_SETS, 16, number of sets (power of 2)
- WORDS_PER_BLOCK, 8, words per line (power of 2)
- Derived widths:
  - BYTE_OFF = log2(DATA_WIDTH/8)
  - WORD_OFF = log2(WORDS_PER_BLOCK)
  - INDEX = log2(NUM_SETS)
  - TAG = ADDR_WIDTH - INDEX - WORD_OFF - BYTE_OFF

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  cache can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_WIDTH  byte address; low BYTE_OFF bits ignored
- req_wdata  in  DATA_WIDTH  store data
- req_be  in  DATA_WIDTH/8  store byte enables
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_WIDTH  load data, or the updated word for stores
- flush  in  1  flush request, sampled only while req_ready = 1
- flush_done  out  1  one-cycle pulse when the flush completes
- mem_req_valid  out  1  memory beat valid
- mem_req_ready  in  1  memory accepts the beat
- mem_req_we  out  1  1 = write beat, 0 = read beat
- mem_addr  out  ADDR_WIDTH  word-aligned byte address of the beat
- mem_wdata  out  DATA_WIDTH  writeback data
- mem_resp_valid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read data

Behaviour:
- Reset:
  - All valid and dirty bits cleared; way w LRU rank = w.
  - Outputs: req_ready=0, resp_valid=0, flush_done=0, mem_req_valid=0, mem_req_we=0, mem_addr=0, mem_wdata=0, resp_rdata=0.
  - req_ready=1 from the first cycle after rst deasserts.
  - rst mid-operation abandons any burst at that clock edge. No partial line is marked valid.
- States:
  - IDLE, WB (writeback), RF_REQ, RF_WAIT, RESP, FLUSH_SCAN, FLUSH_WB.
  - req_ready=1 only in IDLE.
- Accept rule: a request is accepted on a cycle with req_valid & req_ready. If flush is also asserted that cycle, flush wins and the request is not accepted.
- Hit (tag match on a valid way):
  - Completes in the accept cycle; resp_valid=1 on the next cycle.
  - Store: bytes with be=1 are updated, line marked dirty.
  - Hit way becomes rank 0. Ways with rank below the hit way's old rank increment; other ranks are unchanged.
- Miss:
  - Victim = lowest-index invalid way; otherwise the way with rank N_WAYS-1.
  - Request fields are latched at the accept cycle. State goes to WB if the victim is valid and dirty, else RF_REQ.
- WB:
  - Issues WORDS_PER_BLOCK write beats in word order, starting at address {victim_tag, index, 0}.
  - mem_req_valid, mem_addr and mem_wdata are held stable until mem_req_ready. The next beat is presented the cycle after acceptance.
  - After the last beat, go to RF_REQ.
- RF_REQ / RF_WAIT:
  - One read outstanding at a time: issue the read beat, hold it until mem_req_ready, then wait for mem_resp_valid and write the word.
  - Loop until word WORDS_PER_BLOCK-1 is filled, then set tag, valid=1, dirty=0.
- RESP:
  - Perform the latched access on the new line (store sets dirty) and update LRU.
  - resp_valid=1 for one cycle, then return to IDLE.
- Flush:
  - Scans set 0..NUM_SETS-1, way 0..N_WAYS-1.
  - Each valid & dirty line is written back (same beat rules as WB), then dirty is cleared. Valid and LRU are unchanged.
  - After the last way, flush_done=1 for one cycle and return to IDLE.
- mem_resp_valid outside RF_WAIT is ignored. resp_rdata holds its value between responses.

Test Plan:
1. Reset, then load 0x100; memory returns 0xA0+k for beat k → 8 read beats at 0x100,0x104,…,0x11C; resp_valid with resp_rdata=0xA0. Then load 0x104 → hit, resp_valid exactly 1 cycle after accept, data 0xA1, no memory beats.
2. Store 0xDEADBEEF with be=0011 to 0x104 (hit) → response 0x0000BEEF. Subsequent load 0x104 returns 0x0000BEEF; line is dirty.
3. Set 8 conflict sequence: store 0x100, load 0x300, load 0x100, load 0x500 → clean 0x300 is evicted with no write beats. Then load 0x700 → evicts dirty 0x100: 8 write beats to 0x100–0x11C carrying the modified word, then 8 reads from 0x700.
4. Hold mem_req_ready=0 for 5 cycles mid-WB → mem_req_valid, mem_addr and mem_wdata stay stable, req_ready stays 0, and no beat is skipped or duplicated.
5. Two dirty lines present, then flush asserted together with req_valid → request not accepted; exactly 16 write beats; one flush_done pulse. Re-reading both lines hits with no memory traffic.
6. Assert rst during beat 3 of a refill → next cycle mem_req_valid=0 and req_ready=1. Reading the same address misses and refills from beat 0.
